red_pitaya_out_slew: RTL and testbench

Output conditioning stage placed directly downstream of the MIMO PID sum/saturation outputs, with one instance per DAC channel.
- Clamps the 14-bit signed controller output to programmable min/max limits.
- Applies a programmable slew-rate limit, so actuator steps are bounded per update tick.
- Provides a hold (freeze) control.
- Configured over the standard system bus register interface with registered acknowledge.

---
 rtl/red_pitaya_out_slew.sv | 158 +++++++++++++++
 tb/tb_red_pitaya_out_slew.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_out_slew.sv
// Per-channel DAC output conditioning: clamp to min/max, slew-rate limit, freeze, bus registers.
// Optional 32-bit saturation counter at 0x18 when OUT_SLEW_SATCNT_EN is defined.
module red_pitaya_out_slew #(
  parameter int unsigned DW = 14,
  parameter int unsigned PW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic [1:0]    lim_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);

  localparam logic [19:0] AddrCtrl   = 20'h00000;
  localparam logic [19:0] AddrMax    = 20'h00004;
  localparam logic [19:0] AddrMin    = 20'h00008;
  localparam logic [19:0] AddrStep   = 20'h0000C;
  localparam logic [19:0] AddrPresc  = 20'h00010;
  localparam logic [19:0] AddrStatus = 20'h00014;
  localparam logic [19:0] AddrSatcnt = 20'h00018;

  logic                 [1:0]    ctrl_q;
  logic signed          [DW-1:0] max_q, min_q;
  logic                 [DW-1:0] step_q;
  logic                 [PW-1:0] presc_q, cnt_q, cnt_d;
  logic signed          [DW-1:0] x_q, dat_q, dat_d, target, sat_hi;
  logic                 [1:0]    lim_q;
  logic                          at_max, at_min, tick, presc_wr;
  logic signed          [DW:0]   tgt_ext, dat_ext, step_ext, diff, sum;
  logic                 [DW:0]   mag;
  logic                 [31:0]   rd_val, rdata_q;
  logic                          ack_q;
  logic                 [19:0]   addr;
  logic                          unused_bus;

  assign addr       = sys_addr[19:0];
  assign presc_wr   = sys_wen && (addr == AddrPresc);
  assign unused_bus = ^{sys_sel, sys_addr, sys_wdata};

  // Clamp: max first, then min, so min wins when the limits are inverted.
  always_comb begin
    at_max = (x_q > max_q);
    sat_hi = at_max ? max_q : x_q;
    at_min = (sat_hi < min_q);
    target = at_min ? min_q : sat_hi;
  end

  assign tick = (cnt_q == presc_q);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (presc_wr || tick) cnt_d = '0;
  end

  // One extra bit keeps the difference and the stepped value from wrapping.
  always_comb begin
    tgt_ext  = {target[DW-1], target};
    dat_ext  = {dat_q[DW-1], dat_q};
    step_ext = {1'b0, step_q};
    diff     = tgt_ext - dat_ext;
    mag      = diff[DW] ? unsigned'(-diff) : unsigned'(diff);
    sum      = diff[DW] ? (dat_ext - step_ext) : (dat_ext + step_ext);
    dat_d    = dat_q;
    if (ctrl_q[1]) begin
      dat_d = dat_q;
    end else if (!ctrl_q[0]) begin
      dat_d = target;
    end else if (tick) begin
      if (mag <= {1'b0, step_q}) dat_d = target;
      else                       dat_d = sum[DW-1:0];
    end
  end

`ifdef OUT_SLEW_SATCNT_EN
  logic [31:0] satcnt_q, satcnt_d;

  always_comb begin
    satcnt_d = satcnt_q;
    if (sys_wen && (addr == AddrSatcnt)) satcnt_d = '0;
    else if ((at_max || at_min) && !(&satcnt_q)) satcnt_d = satcnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) satcnt_q <= '0;
    else         satcnt_q <= satcnt_d;
  end
`endif

  always_comb begin
    rd_val = '0;
    case (addr)
      AddrCtrl:   rd_val = {30'd0, ctrl_q};
      AddrMax:    rd_val = {{(32-DW){1'b0}}, max_q};
      AddrMin:    rd_val = {{(32-DW){1'b0}}, min_q};
      AddrStep:   rd_val = {{(32-DW){1'b0}}, step_q};
      AddrPresc:  rd_val = {{(32-PW){1'b0}}, presc_q};
      AddrStatus: rd_val = {29'd0, (target != dat_q), at_min, at_max};
`ifdef OUT_SLEW_SATCNT_EN
      AddrSatcnt: rd_val = satcnt_q;
`endif
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q  <= '0;
      max_q   <= {1'b0, {(DW-1){1'b1}}};
      min_q   <= {1'b1, {(DW-1){1'b0}}};
      step_q  <= '1;
      presc_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= sys_wen | sys_ren;
      if (sys_ren) rdata_q <= rd_val;
      if (sys_wen) begin
        case (addr)
          AddrCtrl:  ctrl_q  <= sys_wdata[1:0];
          AddrMax:   max_q   <= sys_wdata[DW-1:0];
          AddrMin:   min_q   <= sys_wdata[DW-1:0];
          AddrStep:  step_q  <= sys_wdata[DW-1:0];
          AddrPresc: presc_q <= sys_wdata[PW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x_q   <= '0;
      dat_q <= '0;
      lim_q <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= dat_i;
      dat_q <= dat_d;
      lim_q <= {at_min, at_max};
      cnt_q <= cnt_d;
    end
  end

  assign dat_o     = dat_q;
  assign lim_o     = lim_q;
  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_out_slew.sv
// Bench for red_pitaya_out_slew: integer reference model checked every cycle plus directed literals.
module tb_red_pitaya_out_slew;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] dat_i;
  logic [13:0] dat_o;
  logic [1:0]  lim_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  red_pitaya_out_slew dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .dat_i    (dat_i),
    .dat_o    (dat_o),
    .lim_o    (lim_o),
    .sys_addr (sys_addr),
    .sys_wdata(sys_wdata),
    .sys_sel  (sys_sel),
    .sys_wen  (sys_wen),
    .sys_ren  (sys_ren),
    .sys_rdata(sys_rdata),
    .sys_err  (sys_err),
    .sys_ack  (sys_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [13:0] v);
    return v[13] ? int'(v) - 16384 : int'(v);
  endfunction

  function automatic logic [13:0] tr(input int v);
    logic [31:0] t;
    t = v;
    return t[13:0];
  endfunction

  // Reference model state, values held as plain signed integers.
  int          m_x, m_dat, m_cnt;
  logic [1:0]  m_lim, m_ctrl;
  logic [13:0] m_max, m_min, m_step;
  logic [15:0] m_presc;
  logic        m_ack;
  logic [31:0] m_rdata, m_sat;

  function automatic int m_target();
    int t;
    t = m_x;
    if (t > sx(m_max)) t = sx(m_max);
    if (t < sx(m_min)) t = sx(m_min);
    return t;
  endfunction

  function automatic logic [1:0] m_flags();
    logic [1:0] f;
    f[0] = m_x > sx(m_max);
    f[1] = (f[0] ? sx(m_max) : m_x) < sx(m_min);
    return f;
  endfunction

  function automatic int m_next_dat();
    int t, d, mag;
    t = m_target();
    if (m_ctrl[1]) return m_dat;
    if (!m_ctrl[0]) return t;
    if (m_cnt != int'(m_presc)) return m_dat;
    d   = t - m_dat;
    mag = (d < 0) ? -d : d;
    if (mag <= int'(m_step)) return t;
    return (d > 0) ? m_dat + int'(m_step) : m_dat - int'(m_step);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[19:0])
      20'h00: return {30'd0, m_ctrl};
      20'h04: return {18'd0, m_max};
      20'h08: return {18'd0, m_min};
      20'h0C: return {18'd0, m_step};
      20'h10: return {16'd0, m_presc};
      20'h14: return {29'd0, (m_target() != m_dat), m_flags()};
`ifdef OUT_SLEW_SATCNT_EN
      20'h18: return m_sat;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_x <= 0; m_dat <= 0; m_cnt <= 0; m_lim <= 2'b00; m_ctrl <= 2'b00;
      m_max <= 14'h1FFF; m_min <= 14'h2000; m_step <= 14'h3FFF; m_presc <= 16'd0;
      m_ack <= 1'b0; m_rdata <= 32'd0; m_sat <= 32'd0;
    end else begin
      m_dat <= m_next_dat();
      m_lim <= m_flags();
      m_x   <= sx(dat_i);
      if (sys_wen && sys_addr[19:0] == 20'h10) m_cnt <= 0;
      else if (m_cnt == int'(m_presc))         m_cnt <= 0;
      else                                     m_cnt <= m_cnt + 1;
      m_ack <= sys_wen | sys_ren;
      if (sys_ren) m_rdata <= m_read(sys_addr);
      if (sys_wen) begin
        case (sys_addr[19:0])
          20'h00: m_ctrl  <= sys_wdata[1:0];
          20'h04: m_max   <= sys_wdata[13:0];
          20'h08: m_min   <= sys_wdata[13:0];
          20'h0C: m_step  <= sys_wdata[13:0];
          20'h10: m_presc <= sys_wdata[15:0];
          default: ;
        endcase
      end
`ifdef OUT_SLEW_SATCNT_EN
      if (sys_wen && sys_addr[19:0] == 20'h18)          m_sat <= 32'd0;
      else if (m_flags() != 2'b00 && m_sat != '1)       m_sat <= m_sat + 32'd1;
`endif
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("model_dat", dat_o, tr(m_dat));
      chk("model_lim", lim_o, m_lim);
      chk("model_ack", sys_ack, m_ack);
      chk("model_rdata", sys_rdata, m_rdata);
      chk("model_err", sys_err, 0);
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(posedge clk); #1;
    sys_wen = 1'b0;
    chk("wr_ack", sys_ack, 1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sys_addr = a; sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_ren = 1'b0;
    chk("rd_ack", sys_ack, 1);
    d = sys_rdata;
  endtask

  task automatic read_expect(input string nm, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    bus_read(a, d);
    chk(nm, d, e);
  endtask

  task automatic wait_change(output logic [13:0] v, output int cyc);
    logic [13:0] p;
    p = dat_o;
    v = p;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (dat_o != p) begin
        v = dat_o;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_change: dat_o stuck at 0x%0h, expected a change within 200 cycles", p);
  endtask

  logic [13:0] v;
  int          c;
  logic [13:0] seq4 [4];

  initial begin
    rstn = 1'b0; dat_i = '0; sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF;
    sys_wen = 1'b0; sys_ren = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_dat", dat_o, 0);
    chk("rst_lim", lim_o, 0);
    chk("rst_ack", sys_ack, 0);
    chk("rst_rdata", sys_rdata, 0);
    read_expect("rst_max", 32'h04, 32'h1FFF);
    @(posedge clk); #1;
    chk("ack_one_cycle", sys_ack, 0);
    read_expect("rst_min", 32'h08, 32'h2000);
    read_expect("rst_step", 32'h0C, 32'h3FFF);
    read_expect("rst_presc", 32'h10, 32'h0);
    read_expect("rst_ctrl", 32'h00, 32'h0);
    read_expect("unmapped", 32'h40, 32'h0);

    // Bypass clamp.
    bus_write(32'h04, 32'h0100);
    bus_write(32'h08, 32'h3F00);
    dat_i = 14'h0500;
    repeat (2) @(posedge clk); #1;
    chk("clamp_max_dat", dat_o, 14'h0100);
    chk("clamp_max_lim", lim_o, 2'b01);
    dat_i = 14'h3000;
    repeat (2) @(posedge clk); #1;
    chk("clamp_min_dat", dat_o, 14'h3F00);
    chk("clamp_min_lim", lim_o, 2'b10);
    bus_write(32'h04, 32'h1FFF);
    bus_write(32'h08, 32'h2000);
    dat_i = 14'h0000;
    repeat (3) @(posedge clk); #1;

    // Slew with prescaler 3.
    bus_write(32'h0C, 32'h10);
    bus_write(32'h10, 32'd3);
    bus_write(32'h00, 32'h1);
    dat_i = 14'h0040;
    for (int k = 0; k < 4; k++) begin
      wait_change(v, c);
      chk("slew_val", v, 16 * (k + 1));
      if (k > 0) chk("slew_gap", c, 4);
    end
    repeat (12) @(posedge clk); #1;
    chk("slew_hold", dat_o, 14'h0040);
    read_expect("status_idle", 32'h14, 32'h0);

    // Full-range step without wrap.
    bus_write(32'h00, 32'h0);
    dat_i = 14'h1FFF;
    repeat (3) @(posedge clk); #1;
    bus_write(32'h0C, 32'h3FFF);
    bus_write(32'h10, 32'd0);
    bus_write(32'h00, 32'h1);
    dat_i = 14'h2000;
    wait_change(v, c);
    chk("big_step", v, 14'h2000);
    bus_write(32'h00, 32'h0);
    dat_i = 14'h1FFF;
    repeat (3) @(posedge clk); #1;
    chk("big_back", dat_o, 14'h1FFF);
    bus_write(32'h0C, 32'h1000);
    bus_write(32'h00, 32'h1);
    dat_i = 14'h2000;
    seq4 = '{14'h0FFF, 14'h3FFF, 14'h2FFF, 14'h2000};
    for (int k = 0; k < 4; k++) begin
      wait_change(v, c);
      chk("wide_val", v, seq4[k]);
      if (k > 0) chk("wide_gap", c, 1);
    end

    // Saturation counter.
    bus_write(32'h00, 32'h0);
    bus_write(32'h04, 32'h0100);
    dat_i = 14'h0000;
    repeat (3) @(posedge clk); #1;
    bus_write(32'h18, 32'h0);
    read_expect("satcnt_clr", 32'h18, 32'h0);
    dat_i = 14'h0500;
    repeat (100) @(posedge clk);
    #1 dat_i = 14'h0000;
    repeat (3) @(posedge clk); #1;
`ifdef OUT_SLEW_SATCNT_EN
    read_expect("satcnt_100", 32'h18, 32'd100);
`else
    read_expect("satcnt_absent", 32'h18, 32'd0);
`endif
    bus_write(32'h18, 32'h0);
    read_expect("satcnt_wr", 32'h18, 32'h0);
    bus_write(32'h04, 32'h1FFF);

    // Freeze mid-slew, resume, then asynchronous reset.
    bus_write(32'h0C, 32'h10);
    bus_write(32'h00, 32'h1);
    dat_i = 14'h0100;
    for (int k = 0; k < 10 && dat_o != 14'h0040; k++) wait_change(v, c);
    bus_write(32'h00, 32'h3);
    chk("freeze_at", dat_o, 14'h0050);
    repeat (10) @(posedge clk); #1;
    chk("freeze_hold", dat_o, 14'h0050);
    bus_write(32'h00, 32'h1);
    wait_change(v, c);
    chk("resume", v, 14'h0060);
    chk("resume_gap", c, 1);
    wait_change(v, c);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_dat", dat_o, 0);
    chk("async_rst_lim", lim_o, 0);
    @(posedge clk); #1 rstn = 1'b1;
    read_expect("post_rst_step", 32'h0C, 32'h3FFF);
    repeat (4) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
